uart_io_sequencer: RTL

Controller that sequences the UART datapath of the I/O manager: it collects bytes delivered by the UART receiver into a small buffer. On a `tx_start` request it streams the buffer back out through the UART transmitter, one byte per transmitter handshake. It sits between the rx/tx serial cores and the board-level controls (`tx_start`, `led`) and owns all scheduling of the single transmitter.

---
 rtl/uart_io_pkg.sv | 12 +
 rtl/uart_io_buffer.sv | 21 ++
 rtl/uart_io_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_io_pkg.sv
// Shared types and constants for the UART I/O sequencer.
// UART_IO_CHECKSUM_EN adds the CSUM state used to append an XOR checksum byte.
package uart_io_pkg;
  localparam int         UART_IO_DEPTH_DEFAULT = 16;
  localparam logic [7:0] CSUM_INIT             = 8'h00;

`ifdef UART_IO_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACK, S_DRAIN, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACK, S_DRAIN} state_t;
`endif
endpackage

// File: rtl/uart_io_buffer.sv
// Byte buffer for the sequencer: synchronous write, combinational read, no reset.
module uart_io_buffer
  import uart_io_pkg::*;
#(
  parameter  int DEPTH = UART_IO_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_io_sequencer.sv
// Collects received bytes and replays them through the UART transmitter on a tx_start edge.
// UART_IO_CHECKSUM_EN appends an XOR checksum byte after the data.
module uart_io_sequencer
  import uart_io_pkg::*;
#(
  parameter  int DEPTH = UART_IO_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_start,
  input  logic        tx_busy,
  output logic        tx_load,
  output logic [7:0]  tx_data,
  output logic [7:0]  led,
  output logic [AW:0] count,
  output logic        busy,
  output logic        overflow
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic          tx_start_q, start_evt;
  logic [AW-1:0] wr_ptr, rd_ptr, last, rd_sel;
  logic [AW:0]   fill;
  logic [7:0]    rd_data, load_byte;
  logic          wr_en, start_go, drain_done, finish, advance, enter_load;

  assign wr_en      = (state == S_IDLE) && rx_valid && (count != FULL);
  assign start_go   = (state == S_IDLE) && start_evt && ((count != '0) || wr_en);
  assign fill       = count + {{AW{1'b0}}, wr_en};
  assign drain_done = (state == S_DRAIN) && !tx_busy;
  assign finish     = drain_done && (state_nxt == S_IDLE);
  assign advance    = drain_done && (state_nxt == S_LOAD);
  assign enter_load = (state != S_LOAD) && (state_nxt == S_LOAD);
  assign rd_sel     = (state == S_IDLE) ? '0 : rd_ptr + 1'b1;
  // A byte written in the same cycle as the start edge is not yet in the RAM.
  assign load_byte  = (wr_en && (wr_ptr == rd_sel)) ? rx_data : rd_data;

  uart_io_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_sel),
    .rdata (rd_data)
  );

`ifdef UART_IO_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum       <= CSUM_INIT;
      csum_phase <= 1'b0;
    end else begin
      if (finish)     csum <= CSUM_INIT;
      else if (wr_en) csum <= csum ^ rx_data;
      if (state == S_CSUM)      csum_phase <= 1'b1;
      else if (state == S_IDLE) csum_phase <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_go) state_nxt = S_LOAD;
      S_LOAD:  if (!tx_busy) state_nxt = S_ACK;
      S_ACK:   if (tx_busy)  state_nxt = S_DRAIN;
      S_DRAIN: if (!tx_busy) begin
`ifdef UART_IO_CHECKSUM_EN
        if (csum_phase)            state_nxt = S_IDLE;
        else if (rd_ptr == last)   state_nxt = S_CSUM;
        else                       state_nxt = S_LOAD;
`else
        state_nxt = (rd_ptr == last) ? S_IDLE : S_LOAD;
`endif
      end
`ifdef UART_IO_CHECKSUM_EN
      S_CSUM:  if (!tx_busy) state_nxt = S_ACK;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_load = (state == S_LOAD) && !tx_busy;
`ifdef UART_IO_CHECKSUM_EN
    if ((state == S_CSUM) && !tx_busy) tx_load = 1'b1;
`endif
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_start_q <= 1'b0;
      start_evt  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last       <= '0;
      count      <= '0;
      led        <= '0;
      overflow   <= 1'b0;
      tx_data    <= '0;
    end else begin
      tx_start_q <= tx_start;
      start_evt  <= tx_start & ~tx_start_q;
      if (finish) begin
        count  <= '0;
        wr_ptr <= '0;
      end else if (wr_en) begin
        count  <= count + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (wr_en) led <= rx_data;
      if (rx_valid && !wr_en) overflow <= 1'b1;
      else if (start_go)      overflow <= 1'b0;
      if (start_go) begin
        rd_ptr <= '0;
        last   <= AW'(fill - 1'b1);
      end else if (advance) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (enter_load) tx_data <= load_byte;
`ifdef UART_IO_CHECKSUM_EN
      else if ((state != S_CSUM) && (state_nxt == S_CSUM)) tx_data <= csum;
`endif
    end
  end
endmodule
